// File: rtl/mem_pkg.sv
// Shared definitions for the load/store MEM stage.
// Latency: n/a (types, defaults and helpers only).
// Backpressure: n/a.
package mem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;
    localparam int RD_W_DEF   = 4;

    // Store-buffer entry at the default widths.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } sb_entry_t;

    // Writeback word layout: destination tag in the upper bits, value below.
    function automatic logic [RD_W_DEF+DATA_W_DEF-1:0] pack_rdval(
        input logic [RD_W_DEF-1:0]   tag,
        input logic [DATA_W_DEF-1:0] val
    );
        return {tag, val};
    endfunction

endpackage

// File: rtl/store_buffer.sv
// Circular store buffer: NUM_LANES enqueue ports in lane order, one drain per cycle, per-lane youngest-match lookup.
// Latency: enqueue visible to lookup the cycle after; lookup is combinational; drain presents head combinationally.
// Backpressure: none internally; the caller must never enqueue more entries than free slots (incl. this cycle's drain).
// Ports: clk/rst, enq_en/enq_addr/enq_data (per lane), lk_addr -> lk_hit/lk_data (per lane),
//        drain/drain_addr/drain_data (head being written this edge), count (occupied entries).
module store_buffer
    import mem_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int NUM_LANES = 2,
    parameter int SB_DEPTH  = 4,
    localparam int PW       = $clog2(SB_DEPTH),
    localparam int CW       = PW + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_LANES-1:0]          enq_en,
    input  logic [NUM_LANES*ADDR_W-1:0]   enq_addr,
    input  logic [NUM_LANES*DATA_W-1:0]   enq_data,
    input  logic [NUM_LANES*ADDR_W-1:0]   lk_addr,
    output logic [NUM_LANES-1:0]          lk_hit,
    output logic [NUM_LANES*DATA_W-1:0]   lk_data,
    output logic                          drain,
    output logic [ADDR_W-1:0]             drain_addr,
    output logic [DATA_W-1:0]             drain_data,
    output logic [CW-1:0]                 count
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t        ents [SB_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] slot [NUM_LANES];
    logic [PW-1:0] age_idx [SB_DEPTH];
    logic [CW-1:0] n_enq;

    // Reset discards pending entries, so nothing may drain on a reset edge.
    assign drain      = (count != '0) && !rst;
    assign drain_addr = ents[head].addr;
    assign drain_data = ents[head].data;

    // Enqueuing lanes pack densely from tail in lane order.
    always_comb begin
        n_enq = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            slot[l] = tail + n_enq[PW-1:0];
            n_enq   = n_enq + CW'(enq_en[l]);
        end
    end

    // age_idx[k] is the entry k places younger than head; index wraps by truncation.
    always_comb begin
        for (int k = 0; k < SB_DEPTH; k++) begin
            age_idx[k] = head + PW'(k);
        end
    end

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            lk_hit[l]                   = 1'b0;
            lk_data[l*DATA_W +: DATA_W] = '0;
            for (int k = 0; k < SB_DEPTH; k++) begin
                if ((CW'(k) < count) && (ents[age_idx[k]].addr == lk_addr[l*ADDR_W +: ADDR_W])) begin
                    lk_hit[l]                   = 1'b1;
                    lk_data[l*DATA_W +: DATA_W] = ents[age_idx[k]].data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (enq_en[l]) begin
                    ents[slot[l]] <= '{addr: enq_addr[l*ADDR_W +: ADDR_W],
                                       data: enq_data[l*DATA_W +: DATA_W]};
                end
            end
            tail <= tail + n_enq[PW-1:0];
            if (drain) begin
                head <= head + 1'b1;
            end
            count <= count + n_enq - CW'(drain);
        end
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM stage: per-lane loads/stores/writebacks, stores via store buffer into word-addressed data memory.
// Latency: 1 cycle from accepted lane input to ldresult/rdvalmem/rdvalid.
// Backpressure: stall (combinational) when this cycle's stores exceed free buffer slots; no lane accepted, caller holds.
// Ports: clk, rst; isld/isst/wben/rd/aluresult/op2 per lane in; stall, ldresult, rdvalmem ({rd,value}), rdvalid, sb_empty out.
module lsu_mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int RD_W      = RD_W_DEF,
    parameter int NUM_LANES = 2,
    parameter int SB_DEPTH  = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_LANES-1:0]                isld,
    input  logic [NUM_LANES-1:0]                isst,
    input  logic [NUM_LANES-1:0]                wben,
    input  logic [NUM_LANES*RD_W-1:0]           rd,
    input  logic [NUM_LANES*DATA_W-1:0]         aluresult,
    input  logic [NUM_LANES*DATA_W-1:0]         op2,
    output logic                                stall,
    output logic [NUM_LANES*DATA_W-1:0]         ldresult,
    output logic [NUM_LANES*(RD_W+DATA_W)-1:0]  rdvalmem,
    output logic [NUM_LANES-1:0]                rdvalid,
    output logic                                sb_empty
);

    localparam int CW = $clog2(SB_DEPTH) + 1;
    localparam int RW = RD_W + DATA_W;

    logic [CW-1:0]               sb_count;
    logic                        sb_drain;
    logic [ADDR_W-1:0]           drain_addr;
    logic [DATA_W-1:0]           drain_data;
    logic [NUM_LANES-1:0]        enq_en;
    logic [NUM_LANES-1:0]        lk_hit;
    logic [NUM_LANES*DATA_W-1:0] lk_data;
    logic [NUM_LANES*ADDR_W-1:0] lane_addr;
    logic [7:0]                  n_st;
    logic [7:0]                  free_slots;
    logic                        accept;
    logic [DATA_W-1:0]           ld_data [NUM_LANES];
    logic [DATA_W-1:0]           mem [2**ADDR_W];

    // Upper aluresult bits are ignored for addressing; aliasing is intended.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_addr[l*ADDR_W +: ADDR_W] = aluresult[l*DATA_W +: ADDR_W];
        end
    end

    // The slot freed by this cycle's drain is usable by this cycle's stores.
    always_comb begin
        n_st = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            n_st = n_st + 8'(isst[l]);
        end
        free_slots = 8'(SB_DEPTH) - 8'(sb_count) + 8'(sb_drain);
        stall      = (n_st > free_slots);
    end

    assign accept   = !stall;
    assign enq_en   = isst & {NUM_LANES{accept}};
    assign sb_empty = (sb_count == '0);

    store_buffer #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NUM_LANES (NUM_LANES),
        .SB_DEPTH  (SB_DEPTH)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .enq_en     (enq_en),
        .enq_addr   (lane_addr),
        .enq_data   (op2),
        .lk_addr    (lane_addr),
        .lk_hit     (lk_hit),
        .lk_data    (lk_data),
        .drain      (sb_drain),
        .drain_addr (drain_addr),
        .drain_data (drain_data),
        .count      (sb_count)
    );

    // Load data: youngest older same-cycle store wins over the buffer, buffer over memory.
    // The memory read sees the pre-drain value; the draining entry is still covered by the buffer hit.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            ld_data[l] = lk_hit[l] ? lk_data[l*DATA_W +: DATA_W] : mem[lane_addr[l*ADDR_W +: ADDR_W]];
            for (int j = 0; j < l; j++) begin
                if (isst[j] && (lane_addr[j*ADDR_W +: ADDR_W] == lane_addr[l*ADDR_W +: ADDR_W])) begin
                    ld_data[l] = op2[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Data memory is not reset.
    always_ff @(posedge clk) begin
        if (sb_drain) begin
            mem[drain_addr] <= drain_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ldresult <= '0;
            rdvalmem <= '0;
            rdvalid  <= '0;
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                rdvalid[l] <= 1'b0;
                if (accept && isld[l]) begin
                    ldresult[l*DATA_W +: DATA_W] <= ld_data[l];
                    rdvalmem[l*RW +: RW]         <= {rd[l*RD_W +: RD_W], ld_data[l]};
                    rdvalid[l]                   <= 1'b1;
                end else if (accept && wben[l]) begin
                    rdvalmem[l*RW +: RW]         <= {rd[l*RD_W +: RD_W], aluresult[l*DATA_W +: DATA_W]};
                    rdvalid[l]                   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage at default parameters (16-bit data, 8-bit address, 4-bit tag, 2 lanes, depth 4).
// Latency: results checked 1 ns after the accepting clock edge.
// Backpressure: stall checked combinationally before the edge; stalled inputs are held.
module tb_lsu_mem_stage;

    logic        clk;
    logic        rst;
    logic [1:0]  isld;
    logic [1:0]  isst;
    logic [1:0]  wben;
    logic [7:0]  rd;
    logic [31:0] aluresult;
    logic [31:0] op2;
    logic        stall;
    logic [31:0] ldresult;
    logic [39:0] rdvalmem;
    logic [1:0]  rdvalid;
    logic        sb_empty;

    int tests = 0;
    int fails = 0;

    lsu_mem_stage dut (
        .clk       (clk),
        .rst       (rst),
        .isld      (isld),
        .isst      (isst),
        .wben      (wben),
        .rd        (rd),
        .aluresult (aluresult),
        .op2       (op2),
        .stall     (stall),
        .ldresult  (ldresult),
        .rdvalmem  (rdvalmem),
        .rdvalid   (rdvalid),
        .sb_empty  (sb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        isld = '0; isst = '0; wben = '0; rd = '0; aluresult = '0; op2 = '0;
    endtask

    task automatic lane(input int l, input logic ld, input logic st, input logic wb,
                        input logic [3:0] r, input logic [15:0] a, input logic [15:0] d);
        isld[l] = ld;
        isst[l] = st;
        wben[l] = wb;
        rd[l*4 +: 4]         = r;
        aluresult[l*16 +: 16] = a;
        op2[l*16 +: 16]       = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all(input string tag);
        idle();
        for (int i = 0; i < 10 && !sb_empty; i++) step();
        chk(tag, {31'd0, sb_empty}, 32'd1);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        // Reset state
        chk("rst_ldresult", ldresult, 32'h0);
        chk("rst_rdvalmem", rdvalmem[31:0], 32'h0);
        chk("rst_rdvalid", {30'd0, rdvalid}, 32'h0);
        chk("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);

        // Preload mem[2] = 0x1234 through the store path
        lane(0, 0, 1, 0, 4'h0, 16'h0002, 16'h1234);
        step();
        chk("pre_notempty", {31'd0, sb_empty}, 32'd0);
        drain_all("pre_empty");

        // T1: load from memory on lane 0, wben on lane 1
        lane(0, 1, 0, 0, 4'h3, 16'h0002, 16'h0000);
        lane(1, 0, 0, 1, 4'h7, 16'h00C3, 16'h0000);
        step();
        chk("t1_ld0", ldresult[15:0], 32'h1234);
        chk("t1_rv0", rdvalmem[19:0], 32'h31234);
        chk("t1_rv1_wben", rdvalmem[39:20], 32'h700C3);
        chk("t1_rdvalid", {30'd0, rdvalid}, 32'h3);
        chk("t1_ld1_unchanged", ldresult[31:16], 32'h0);

        // T2: store then load the next cycle, forwarded from the draining entry
        idle();
        lane(0, 0, 1, 0, 4'h0, 16'h000A, 16'hAAAA);
        step();
        idle();
        lane(0, 1, 0, 0, 4'h2, 16'h000A, 16'h0000);
        #1;
        chk("t2_sb_notempty", {31'd0, sb_empty}, 32'd0);
        step();
        chk("t2_fwd", ldresult[15:0], 32'hAAAA);
        chk("t2_rv0", rdvalmem[19:0], 32'h2AAAA);
        chk("t2_sb_empty", {31'd0, sb_empty}, 32'd1);
        idle();
        lane(0, 1, 0, 0, 4'h2, 16'hFF0A, 16'h0000);   // aliased address, read from memory
        step();
        chk("t2_mem_alias", ldresult[15:0], 32'hAAAA);
        idle();
        step();
        chk("t2_idle_rdvalid", {30'd0, rdvalid}, 32'h0);
        chk("t2_idle_ld_hold", ldresult[15:0], 32'hAAAA);
        chk("t2_idle_rv0_hold", rdvalmem[19:0], 32'h2AAAA);
        chk("t2_idle_rv1_hold", rdvalmem[39:20], 32'h700C3);

        // T3: older same-cycle store forwards; younger one does not
        lane(0, 0, 1, 0, 4'h0, 16'h0010, 16'hBEEF);
        lane(1, 1, 0, 0, 4'h5, 16'h0010, 16'h0000);
        step();
        chk("t3_fwd_ld1", ldresult[31:16], 32'hBEEF);
        chk("t3_fwd_rv1", rdvalmem[39:20], 32'h5BEEF);
        chk("t3_rdvalid", {30'd0, rdvalid}, 32'h2);
        drain_all("t3_empty_a");
        lane(0, 1, 0, 0, 4'h6, 16'h0010, 16'h0000);
        lane(1, 0, 1, 0, 4'h0, 16'h0010, 16'hCAFE);
        step();
        chk("t3_swap_ld0", ldresult[15:0], 32'hBEEF);
        chk("t3_swap_rdvalid", {30'd0, rdvalid}, 32'h1);
        drain_all("t3_empty_b");
        lane(0, 1, 0, 0, 4'h6, 16'h0010, 16'h0000);
        step();
        chk("t3_mem_cafe", ldresult[15:0], 32'hCAFE);

        // T5: youngest buffer entry wins; same-cycle store beats the buffer
        idle();
        lane(0, 0, 1, 0, 4'h0, 16'h0005, 16'h1111);
        lane(1, 0, 1, 0, 4'h0, 16'h0005, 16'h2222);
        step();
        idle();
        lane(0, 1, 0, 0, 4'h1, 16'h0005, 16'h0000);
        step();
        chk("t5_youngest", ldresult[15:0], 32'h2222);
        idle();
        lane(0, 0, 1, 0, 4'h0, 16'h0005, 16'h3333);
        lane(1, 1, 0, 0, 4'h9, 16'h0005, 16'h0000);
        step();
        chk("t5_lane_over_sb", ldresult[31:16], 32'h3333);
        drain_all("t5_empty");
        lane(0, 1, 0, 0, 4'h1, 16'h0005, 16'h0000);
        step();
        chk("t5_mem_final", ldresult[15:0], 32'h3333);

        // T4: two stores per cycle until the buffer fills and stalls
        idle();
        lane(0, 0, 1, 0, 4'h0, 16'h0020, 16'h0A01);
        lane(1, 0, 1, 0, 4'h0, 16'h0021, 16'h0A02);
        #1;
        chk("t4_stall_a", {31'd0, stall}, 32'd0);
        step();
        lane(0, 0, 1, 0, 4'h0, 16'h0022, 16'h0B01);
        lane(1, 0, 1, 0, 4'h0, 16'h0020, 16'h0B02);
        #1;
        chk("t4_stall_b", {31'd0, stall}, 32'd0);
        step();
        lane(0, 0, 1, 0, 4'h0, 16'h0023, 16'h0C01);
        lane(1, 0, 1, 0, 4'h0, 16'h0021, 16'h0C02);
        #1;
        chk("t4_stall_c", {31'd0, stall}, 32'd0);
        step();
        lane(0, 0, 1, 0, 4'h0, 16'h0020, 16'h0D01);
        lane(1, 0, 1, 0, 4'h0, 16'h0024, 16'h0D02);
        #1;
        chk("t4_stall_full", {31'd0, stall}, 32'd1);
        step();   // inputs held while stalled
        chk("t4_stall_rdvalid", {30'd0, rdvalid}, 32'h0);
        chk("t4_stall_release", {31'd0, stall}, 32'd0);
        step();
        drain_all("t4_empty");
        lane(0, 1, 0, 0, 4'h1, 16'h0020, 16'h0000);
        lane(1, 1, 0, 0, 4'h2, 16'h0021, 16'h0000);
        step();
        chk("t4_m20", ldresult[15:0], 32'h0D01);
        chk("t4_m21", ldresult[31:16], 32'h0C02);
        lane(0, 1, 0, 0, 4'h1, 16'h0022, 16'h0000);
        lane(1, 1, 0, 0, 4'h2, 16'h0023, 16'h0000);
        step();
        chk("t4_m22", ldresult[15:0], 32'h0B01);
        chk("t4_m23", ldresult[31:16], 32'h0C01);
        lane(0, 1, 0, 0, 4'h1, 16'h0024, 16'h0000);
        lane(1, 0, 0, 0, 4'h0, 16'h0000, 16'h0000);
        step();
        chk("t4_m24", ldresult[15:0], 32'h0D02);

        // T6: reset with three pending entries discards them
        idle();
        lane(0, 0, 1, 0, 4'h0, 16'h0030, 16'h7000);
        lane(1, 0, 1, 0, 4'h0, 16'h0031, 16'h7001);
        step();
        lane(0, 0, 1, 0, 4'h0, 16'h0032, 16'h7002);
        lane(1, 0, 1, 0, 4'h0, 16'h0033, 16'h7003);
        step();
        drain_all("t6_pre_empty");
        lane(0, 0, 1, 0, 4'h0, 16'h0031, 16'h6001);
        lane(1, 0, 1, 0, 4'h0, 16'h0032, 16'h6002);
        step();
        lane(0, 0, 1, 0, 4'h0, 16'h0033, 16'h6003);
        lane(1, 0, 1, 0, 4'h0, 16'h0030, 16'h6000);
        step();   // 0x31 drained; 0x32, 0x33, 0x30 pending
        chk("t6_pending", {31'd0, sb_empty}, 32'd0);
        idle();
        lane(0, 0, 0, 1, 4'h4, 16'h1234, 16'h0000);
        lane(1, 0, 1, 0, 4'h0, 16'h0032, 16'h9999);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        chk("t6_sb_empty", {31'd0, sb_empty}, 32'd1);
        chk("t6_rdvalid", {30'd0, rdvalid}, 32'h0);
        chk("t6_rdvalmem", rdvalmem[31:0], 32'h0);
        step();
        chk("t6_sb_empty_after", {31'd0, sb_empty}, 32'd1);
        lane(0, 1, 0, 0, 4'h1, 16'h0030, 16'h0000);
        lane(1, 1, 0, 0, 4'h2, 16'h0031, 16'h0000);
        step();
        chk("t6_m30_kept", ldresult[15:0], 32'h7000);
        chk("t6_m31_drained", ldresult[31:16], 32'h6001);
        lane(0, 1, 0, 0, 4'h1, 16'h0032, 16'h0000);
        lane(1, 1, 0, 0, 4'h2, 16'h0033, 16'h0000);
        step();
        chk("t6_m32_kept", ldresult[15:0], 32'h7002);
        chk("t6_m33_kept", ldresult[31:16], 32'h7003);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
